spi_slave_regif: RTL and testbench

Synthesizable SPI slave register interface: the DUT-side counterpart that consumes the frames produced by the simulation SPI master. It receives 16-bit frames: a 5-bit command (1 R/W bit, 4 address bits) followed by 11 data bits, MSB first. Writes land in a 16 x 11 register file. Reads return the addressed register on `spi_miso` during the data phase. All SPI pins are oversampled in the system clock domain; the register file feeds downstream logic in parallel.

---
 rtl/spi_slave_pkg.sv | 23 ++
 rtl/spi_slave_regif_if.sv | 25 ++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_regif.sv | 181 ++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared widths, opcodes and FSM encoding for the SPI slave register interface.
// Frames are a 5-bit command (R/W + 4-bit address) followed by 11 data bits, MSB first.
package spi_slave_pkg;

    localparam int CMD_WIDTH  = 5;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 11;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    localparam logic WRITE = 1'b0;
    localparam logic READ  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ID_ADDR  = 4'hF;
    localparam logic [DATA_WIDTH-1:0] ID_VALUE = 11'h305;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_slave_regif_if.sv
// SPI pins plus the parallel register-file outputs of the slave.
// The slave modport is the design side, the master modport is the driving side.
interface spi_slave_regif_if;
    import spi_slave_pkg::*;

    logic                           spi_cs_n;
    logic                           spi_sclk;
    logic                           spi_mosi;
    logic                           spi_miso;
    logic [NUM_REGS*DATA_WIDTH-1:0] reg_out;
    logic                           wr_pulse;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic                           frame_err;

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi,
        output spi_miso, reg_out, wr_pulse, wr_addr, frame_err
    );

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi,
        input  spi_miso, reg_out, wr_pulse, wr_addr, frame_err
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by a one-flop edge detector for a single async input.
// RESET_VAL should match the pin's idle level so reset release produces no false edge.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI slave with a 16 x 11 register file; all SPI pins are oversampled in the clk domain.
// Address F is a read-only ID; writes to it are dropped.
module spi_slave_regif
    import spi_slave_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    spi_slave_regif_if.slave   bus
);

    localparam logic [3:0] LAST_CMD_BIT  = 4'(CMD_WIDTH - 1);
    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH - 1);

    logic w_cs_rise, w_cs_fall, w_unused_cs_level;
    logic w_sclk_rise, w_sclk_fall, w_unused_sclk_level;
    logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_din(bus.spi_cs_n),
        .o_level(w_unused_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_din(bus.spi_sclk),
        .o_level(w_unused_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .i_din(bus.spi_mosi),
        .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
    );

    state_t                r_state, w_state_next;
    logic [3:0]            r_bit_cnt, w_bit_cnt_next;
    logic [CMD_WIDTH-1:0]  r_cmd, w_cmd_next;
    logic [DATA_WIDTH-2:0] r_wr_shift, w_wr_shift_next;
    // Read path keeps the current bit in r_miso and only the remaining bits here.
    logic [DATA_WIDTH-2:0] r_rd_shift, w_rd_shift_next;
    logic                  r_rise_seen, w_rise_seen_next;
    logic                  r_miso, w_miso_next;
    logic                  r_wr_pulse;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic                  r_frame_err, w_frame_err_next;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic [CMD_WIDTH-1:0]  w_cmd_shifted;
    logic [DATA_WIDTH-1:0] w_data_shifted;
    logic [DATA_WIDTH-1:0] w_read_value;

    assign w_cmd_shifted  = {r_cmd[CMD_WIDTH-2:0], w_mosi};
    assign w_data_shifted = {r_wr_shift, w_mosi};
    assign w_read_value   = (w_cmd_shifted[ADDR_WIDTH-1:0] == ID_ADDR)
                          ? ID_VALUE : r_regs[w_cmd_shifted[ADDR_WIDTH-1:0]];

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_cmd_next       = r_cmd;
        w_wr_shift_next  = r_wr_shift;
        w_rd_shift_next  = r_rd_shift;
        w_rise_seen_next = r_rise_seen;
        w_miso_next      = 1'b0;
        w_frame_err_next = 1'b0;
        w_commit         = 1'b0;

        // A new chip-select assertion restarts the frame from any state.
        if (w_cs_fall) begin
            w_state_next     = CMD;
            w_bit_cnt_next   = '0;
            w_cmd_next       = '0;
            w_wr_shift_next  = '0;
            w_rd_shift_next  = '0;
            w_rise_seen_next = 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                CMD: begin
                    if (w_cs_rise) begin
                        w_state_next     = IDLE;
                        w_frame_err_next = 1'b1;
                    end else if (w_sclk_fall) begin
                        w_cmd_next = w_cmd_shifted;
                        if (r_bit_cnt == LAST_CMD_BIT) begin
                            w_state_next     = DATA;
                            w_bit_cnt_next   = '0;
                            w_wr_shift_next  = '0;
                            w_rd_shift_next  = w_read_value[DATA_WIDTH-2:0];
                            w_rise_seen_next = 1'b0;
                            w_miso_next      = (w_cmd_shifted[CMD_WIDTH-1] == READ)
                                             & w_read_value[DATA_WIDTH-1];
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    w_miso_next = r_miso;
                    if (w_cs_rise) begin
                        w_state_next     = IDLE;
                        w_frame_err_next = 1'b1;
                        w_miso_next      = 1'b0;
                    end else begin
                        // The MSB is already on miso; shifting starts with the second rise.
                        if (w_sclk_rise) begin
                            if (r_rise_seen) begin
                                w_rd_shift_next = {r_rd_shift[DATA_WIDTH-3:0], 1'b0};
                                w_miso_next     = (r_cmd[CMD_WIDTH-1] == READ)
                                                & r_rd_shift[DATA_WIDTH-2];
                            end
                            w_rise_seen_next = 1'b1;
                        end
                        if (w_sclk_fall) begin
                            w_wr_shift_next = w_data_shifted[DATA_WIDTH-2:0];
                            if (r_bit_cnt == LAST_DATA_BIT) begin
                                w_state_next   = DONE;
                                w_bit_cnt_next = '0;
                                w_miso_next    = 1'b0;
                                w_commit       = (r_cmd[CMD_WIDTH-1] == WRITE)
                                               && (r_cmd[ADDR_WIDTH-1:0] != ID_ADDR);
                            end else begin
                                w_bit_cnt_next = r_bit_cnt + 4'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (w_cs_rise) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_cmd       <= '0;
            r_wr_shift  <= '0;
            r_rd_shift  <= '0;
            r_rise_seen <= 1'b0;
            r_miso      <= 1'b0;
            r_wr_pulse  <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_cmd       <= w_cmd_next;
            r_wr_shift  <= w_wr_shift_next;
            r_rd_shift  <= w_rd_shift_next;
            r_rise_seen <= w_rise_seen_next;
            r_miso      <= w_miso_next;
            r_wr_pulse  <= w_commit;
            r_frame_err <= w_frame_err_next;
            if (w_commit) begin
                r_wr_addr                         <= r_cmd[ADDR_WIDTH-1:0];
                r_regs[r_cmd[ADDR_WIDTH-1:0]]     <= w_data_shifted;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign bus.reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

    assign bus.spi_miso  = r_miso;
    assign bus.wr_pulse  = r_wr_pulse;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: stimulus pushes expected events into a queue,
// a monitor pops and compares on wr_pulse, frame_err and completed reads.
module tb_spi_slave_regif;
    import spi_slave_pkg::*;

    localparam int RW = NUM_REGS * DATA_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_regif_if bus ();

    spi_slave_regif dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum int {EV_WR = 0, EV_ERR = 1, EV_RD = 2} ev_kind_t;
    typedef struct {
        ev_kind_t              kind;
        logic [3:0]            addr;
        logic [10:0]           data;
        logic [RW-1:0]         regs;
    } exp_t;

    exp_t        exp_q [$];
    logic [10:0] model [NUM_REGS];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        rd_valid = 1'b0;
    logic [10:0] rd_obs   = '0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [RW-1:0] model_flat();
        logic [RW-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_WIDTH +: DATA_WIDTH] = model[i];
        return f;
    endfunction

    task automatic take(input ev_kind_t k);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d expected none", int'(k));
        end else begin
            e = exp_q.pop_front();
            check("event_kind", RW'(int'(k)), RW'(int'(e.kind)));
            if (k == EV_WR) begin
                check("wr_addr", RW'(bus.wr_addr), RW'(e.addr));
                check("reg_out_after_write", bus.reg_out, e.regs);
            end else if (k == EV_RD) begin
                check("read_data", RW'(rd_obs), RW'(e.data));
            end
            $display("txn kind=%0d addr=%0h data=%0h", int'(k), e.addr, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_pulse)  take(EV_WR);
            if (bus.frame_err) take(EV_ERR);
            if (rd_valid)      take(EV_RD);
        end
    end

    task automatic spi_xfer(input logic [15:0] word, input int ncyc, input bit end_cs,
                            input bit chk_miso, output logic [10:0] rd);
        rd = '0;
        bus.spi_cs_n = 1'b0;
        #60;
        for (int i = 0; i < ncyc; i++) begin
            bus.spi_mosi = (i < 16) ? word[15-i] : 1'b1;
            #20 bus.spi_sclk = 1'b1;
            #50;
            if (chk_miso && i < 16 && (i < 5 || word[15] == WRITE))
                check("miso_low_outside_read_data", RW'(bus.spi_miso), '0);
            if (i >= 5 && i < 16) rd[15-i] = bus.spi_miso;
            bus.spi_sclk = 1'b0;
            #30;
        end
        if (end_cs) begin
            #30 bus.spi_cs_n = 1'b1;
            #100;
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [10:0] d, input int ncyc);
        exp_t        e;
        logic [10:0] dummy;
        if (ncyc < 16) begin
            e.kind = EV_ERR; e.addr = a; e.data = d; e.regs = '0;
            exp_q.push_back(e);
        end else if (a != ID_ADDR) begin
            model[a] = d;
            e.kind = EV_WR; e.addr = a; e.data = d; e.regs = model_flat();
            exp_q.push_back(e);
        end
        spi_xfer({WRITE, a, d}, ncyc, 1'b1, 1'b1, dummy);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [10:0] exp_d);
        exp_t        e;
        logic [10:0] rd;
        e.kind = EV_RD; e.addr = a; e.data = exp_d; e.regs = '0;
        exp_q.push_back(e);
        spi_xfer({READ, a, 11'h000}, 16, 1'b1, 1'b1, rd);
        @(negedge clk); #1;
        rd_obs   = rd;
        rd_valid = 1'b1;
        @(negedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_reg_out"},   bus.reg_out, '0);
        check({tag, "_wr_pulse"},  RW'(bus.wr_pulse), '0);
        check({tag, "_wr_addr"},   RW'(bus.wr_addr), '0);
        check({tag, "_frame_err"}, RW'(bus.frame_err), '0);
        check({tag, "_miso"},      RW'(bus.spi_miso), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] dummy;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        do_write(4'h3, 11'h5A5, 16);
        check("slot3_value", RW'(bus.reg_out[3*11 +: 11]), RW'(11'h5A5));
        do_read(4'h3, 11'h5A5);

        do_read(4'hF, 11'h305);
        do_write(4'hF, 11'h7FF, 16);
        check("id_write_dropped", bus.reg_out, model_flat());
        do_read(4'hF, 11'h305);

        do_write(4'h2, 11'h3C3, 9);
        check("slot2_after_abort", RW'(bus.reg_out[2*11 +: 11]), '0);
        do_write(4'h2, 11'h3C3, 16);
        check("slot2_after_full", RW'(bus.reg_out[2*11 +: 11]), RW'(11'h3C3));

        do_write(4'h1, 11'h123, 20);
        check("slot1_long_frame", RW'(bus.reg_out[1*11 +: 11]), RW'(11'h123));

        do_write(4'h4, 11'h0AA, 16);
        repeat (4) @(posedge clk);
        check("queue_empty_before_reset", RW'(exp_q.size()), '0);
        spi_xfer({WRITE, 4'h6, 11'h7FF}, 9, 1'b0, 1'b0, dummy);
        #20 rst_n = 1'b0;
        check_reset_outputs("mid_frame_reset");
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        repeat (4) @(posedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        check_reset_outputs("after_reset");
        do_read(4'h4, 11'h000);

        repeat (10) @(posedge clk);
        check("queue_drained", RW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
